// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and an
// optional two-entry skid buffer that keeps in_ready off the out_ready path.
module pipe_stage_skid #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter bit               SKID   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             main_valid;
    logic             in_ready_q;
    logic [1:0]       count_q;
    logic             accept;
    logic             drain;

    // NOTE: in skid mode in_ready is a flop so back-pressure never forms a
    // combinational loop from out_ready back to the upstream stage.
    assign in_ready  = SKID ? in_ready_q : (!main_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign count     = count_q;

    always_ff @(posedge clk) begin
        // NOTE: payload registers are reset too, because an empty stage must
        // present BUBBLE on out_data rather than stale contents.
        if (reset || flush) begin
            state      <= EMPTY;
            main_data  <= BUBBLE;
            skid_data  <= BUBBLE;
            main_valid <= 1'b0;
            in_ready_q <= 1'b1;
            count_q    <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state      <= ONE;
                        main_data  <= in_data;
                        main_valid <= 1'b1;
                        count_q    <= 2'd1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_data <= in_data;
                    end else if (accept && SKID) begin
                        state      <= FULL;
                        skid_data  <= in_data;
                        in_ready_q <= 1'b0;
                        count_q    <= 2'd2;
                    end else if (drain) begin
                        state      <= EMPTY;
                        main_data  <= BUBBLE;
                        main_valid <= 1'b0;
                        count_q    <= 2'd0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the head can move.
                    if (drain) begin
                        state      <= ONE;
                        main_data  <= skid_data;
                        skid_data  <= BUBBLE;
                        in_ready_q <= 1'b1;
                        count_q    <= 2'd1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    main_data  <= BUBBLE;
                    skid_data  <= BUBBLE;
                    main_valid <= 1'b0;
                    in_ready_q <= 1'b1;
                    count_q    <= 2'd0;
                end
            endcase
        end
    end

endmodule
